// File: rtl/wb_port_arbiter_pkg.sv
// Shared request type, register-zero constant and arbiter state encoding
// for the register-file write-port arbiter.
package wb_pkg;

  typedef struct packed {
    logic        we;
    logic [4:0]  add;
    logic [31:0] data;
  } wb_req_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    EMPTY,
    PENDING,
    DRAIN
  } arb_state_e;

  // A write only does anything when enabled and not aimed at register zero.
  function automatic logic is_live(input logic we, input logic [4:0] add);
    return we && (add != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback stage / long-latency unit (master side)
// and the write-port arbiter (slave side).
interface wb_port_arbiter_if;
  logic [31:0] pipe_data;
  logic        pipe_write_reg;
  logic [4:0]  pipe_add;
  logic        pipe_stall;
  logic        lu_valid;
  logic [31:0] lu_data;
  logic [4:0]  lu_add;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_add;
  logic [31:0] rf_data;

  modport master (
    output pipe_data, pipe_write_reg, pipe_add,
    output lu_valid, lu_data, lu_add,
    input  pipe_stall, lu_ready,
    input  rf_we, rf_add, rf_data
  );

  modport slave (
    input  pipe_data, pipe_write_reg, pipe_add,
    input  lu_valid, lu_data, lu_add,
    output pipe_stall, lu_ready,
    output rf_we, rf_add, rf_data
  );
endinterface

// File: rtl/wb_hold_fifo.sv
// Circular hold buffer for long-latency results with per-entry kill by address.
// Latency: head visible the cycle after push; count/full/empty are registered.
// Backpressure: caller must not push when full nor pop when empty.
module wb_hold_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  input  logic             kill,
  input  logic [4:0]       kill_add,
  output wb_req_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Kill before push so a same-cycle push decides its own liveness.
    for (int i = 0; i < DEPTH; i++) begin
      if (kill && (mem_q[i].add == kill_add)) begin
        mem_d[i].we = 1'b0;
      end
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between writeback and long-latency results.
// Latency: one cycle from grant to registered rf_* outputs.
// Backpressure: lu_ready while buffer not full; one-cycle pipe_stall forces a drain.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [ST_W-1:0] STARVE_MAX = ST_W'(STARVE_LIMIT);

  wb_req_t          rf_q, rf_d;
  wb_req_t          head, push_req;
  logic             push, pop, kill, bypass;
  logic             pipe_live, pipe_won, lu_xfer, stall_cond;
  logic [CNT_W-1:0] count, count_nx;
  logic             full, empty;
  logic [ST_W-1:0]  starve_q, starve_d;
  arb_state_e       state_q, state_d;

  wb_hold_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .kill     (kill),
    .kill_add (bus.pipe_add),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    pipe_live = is_live(bus.pipe_write_reg, bus.pipe_add);
    lu_xfer   = bus.lu_valid && !full;
    rf_d      = '0;
    pop       = 1'b0;
    kill      = 1'b0;
    bypass    = 1'b0;
    pipe_won  = 1'b0;
    starve_d  = '0;
    if (state_q == DRAIN) begin
      pop  = !empty;
      rf_d = head;
    end else if (pipe_live) begin
      pipe_won = 1'b1;
      kill     = 1'b1;
      rf_d     = '{we: 1'b1, add: bus.pipe_add, data: bus.pipe_data};
      if (!empty) begin
        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + ST_W'(1);
      end
    end else if (!empty) begin
      pop  = 1'b1;
      rf_d = head;
    end else if (lu_xfer) begin
      bypass = 1'b1;
      rf_d   = '{we: is_live(1'b1, bus.lu_add), add: bus.lu_add, data: bus.lu_data};
    end
    push     = lu_xfer && !bypass;
    // A same-cycle pipe write to the same register supersedes the LU result.
    push_req = '{we:   is_live(1'b1, bus.lu_add) && !(pipe_won && (bus.lu_add == bus.pipe_add)),
                 add:  bus.lu_add,
                 data: bus.lu_data};
    count_nx   = count + CNT_W'(push) - CNT_W'(pop);
    stall_cond = pipe_won && !empty && (starve_d == STARVE_MAX);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (count_nx != '0) state_d = PENDING;
      end
      PENDING: begin
        if (stall_cond)             state_d = DRAIN;
        else if (count_nx == '0)    state_d = EMPTY;
      end
      DRAIN: begin
        state_d = (count_nx != '0) ? PENDING : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q     <= '0;
      starve_q <= '0;
      state_q  <= EMPTY;
    end else begin
      rf_q     <= rf_d;
      starve_q <= starve_d;
      state_q  <= state_d;
    end
  end

  assign bus.lu_ready   = !full;
  assign bus.pipe_stall = (state_q == DRAIN);
  assign bus.rf_we      = rf_q.we;
  assign bus.rf_add     = rf_q.add;
  assign bus.rf_data    = rf_q.data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table plus randomized run against a queue model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst, pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        we;
    logic [4:0]  add;
    logic [31:0] data;
    logic        stall, rdy;
  } vec_t;

  typedef struct packed {
    logic        live;
    logic [4:0]  add;
    logic [31:0] data;
  } ent_t;

  vec_t tbl[$];

  // Behavioural model state
  ent_t        mq[$];
  int          m_starve;
  logic        m_stall;
  logic        m_we;
  logic [4:0]  m_add;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    reset              = rst;
    bus.pipe_write_reg = pw;
    bus.pipe_add       = pa;
    bus.pipe_data      = pd;
    bus.lu_valid       = lv;
    bus.lu_add         = la;
    bus.lu_data        = ld;
  endtask

  task automatic check_outputs(input string tag, input logic we, input logic [4:0] add,
                               input logic [31:0] data, input logic stall, input logic rdy);
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(we));
    if (we) begin
      chk({tag, ".rf_add"}, 32'(bus.rf_add), 32'(add));
      chk({tag, ".rf_data"}, bus.rf_data, data);
    end
    chk({tag, ".pipe_stall"}, 32'(bus.pipe_stall), 32'(stall));
    chk({tag, ".lu_ready"}, 32'(bus.lu_ready), 32'(rdy));
  endtask

  task automatic row(input int rst, input int pw, input int pa, input int pd,
                     input int lv, input int la, input int ld,
                     input int we, input int add, input int data, input int stall, input int rdy);
    vec_t v;
    v.rst = rst[0]; v.pw = pw[0]; v.pa = 5'(pa); v.pd = 32'(pd);
    v.lv = lv[0]; v.la = 5'(la); v.ld = 32'(ld);
    v.we = we[0]; v.add = 5'(add); v.data = 32'(data);
    v.stall = stall[0]; v.rdy = rdy[0];
    tbl.push_back(v);
  endtask

  // Queue-level reference: one call per clock with that cycle's inputs.
  task automatic model_step(input logic rst, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                            input logic lv, input logic [4:0] la, input logic [31:0] ld);
    ent_t e;
    bit   won, byp, xfer, had;
    if (rst) begin
      mq.delete();
      m_starve = 0; m_stall = 0; m_we = 0; m_add = '0; m_data = '0;
      return;
    end
    xfer = lv && (mq.size() < DEPTH);
    had  = (mq.size() > 0);
    won  = 0; byp = 0;
    m_we = 0; m_add = '0; m_data = '0;
    if (m_stall) begin
      e = mq.pop_front();
      m_we = e.live; m_add = e.add; m_data = e.data;
      m_starve = 0;
    end else if (pw && pa != 5'd0) begin
      won = 1;
      m_we = 1; m_add = pa; m_data = pd;
      foreach (mq[i]) if (mq[i].add == pa) mq[i].live = 1'b0;
      m_starve = had ? ((m_starve < LIMIT) ? m_starve + 1 : m_starve) : 0;
    end else if (had) begin
      e = mq.pop_front();
      m_we = e.live; m_add = e.add; m_data = e.data;
      m_starve = 0;
    end else if (xfer) begin
      byp = 1;
      m_we = (la != 5'd0); m_add = la; m_data = ld;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
    if (xfer && !byp) begin
      e.live = (la != 5'd0) && !(won && la == pa);
      e.add  = la;
      e.data = ld;
      mq.push_back(e);
    end
    m_stall = won && had && (m_starve == LIMIT);
  endtask

  logic        r_rst, r_pw, r_lv;
  logic [4:0]  r_pa, r_la;
  logic [31:0] r_pd, r_ld;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // rst pw pa pd      lv la ld      we add data    stall rdy
    row(1, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);
    // Idle pipe: LU result bypasses straight to the port.
    row(0, 0, 0,  0,       1, 5,  'h1234,  1, 5,  'h1234,  0, 1);
    row(0, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);
    // Continuous pipe writes starve two buffered results.
    row(0, 1, 20, 'h100,   1, 7,  'h77,    1, 20, 'h100,   0, 1);
    row(0, 1, 21, 'h101,   1, 8,  'h88,    1, 21, 'h101,   0, 0);
    row(0, 1, 22, 'h102,   0, 0,  0,       1, 22, 'h102,   0, 0);
    row(0, 1, 23, 'h103,   0, 0,  0,       1, 23, 'h103,   0, 0);
    row(0, 1, 24, 'h104,   0, 0,  0,       1, 24, 'h104,   1, 0);
    row(0, 1, 25, 'h105,   0, 0,  0,       1, 7,  'h77,    0, 1);
    row(0, 1, 25, 'h105,   0, 0,  0,       1, 25, 'h105,   0, 1);
    row(0, 1, 26, 'h106,   0, 0,  0,       1, 26, 'h106,   0, 1);
    row(0, 1, 27, 'h107,   0, 0,  0,       1, 27, 'h107,   0, 1);
    row(0, 1, 28, 'h108,   0, 0,  0,       1, 28, 'h108,   1, 1);
    row(0, 1, 29, 'h109,   0, 0,  0,       1, 8,  'h88,    0, 1);
    row(0, 1, 29, 'h109,   0, 0,  0,       1, 29, 'h109,   0, 1);
    // WAW kill: buffered add 9 is superseded by the pipe write.
    row(0, 1, 10, 'h10,    1, 9,  'h99,    1, 10, 'h10,    0, 1);
    row(0, 1, 9,  'hAAAA,  0, 0,  0,       1, 9,  'hAAAA,  0, 1);
    row(0, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);
    row(0, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);
    // Pipe write to r0 never wins; LU bypass takes the slot.
    row(0, 1, 0,  'hDEAD,  1, 3,  'h33,    1, 3,  'h33,    0, 1);
    row(0, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);
    // Full buffer: dequeue cycle refuses the offer, next cycle accepts.
    row(0, 1, 11, 1,       1, 12, 'hC,     1, 11, 1,       0, 1);
    row(0, 1, 13, 2,       1, 14, 'hE,     1, 13, 2,       0, 0);
    row(0, 0, 0,  0,       1, 15, 'hF,     1, 12, 'hC,     0, 1);
    row(0, 1, 16, 3,       1, 15, 'hF,     1, 16, 3,       0, 0);
    row(0, 0, 0,  0,       0, 0,  0,       1, 14, 'hE,     0, 1);
    row(0, 0, 0,  0,       0, 0,  0,       1, 15, 'hF,     0, 1);
    row(0, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);
    // Reset with two buffered results discards them.
    row(0, 1, 17, 4,       1, 18, 'h12,    1, 17, 4,       0, 1);
    row(0, 1, 19, 5,       1, 20, 'h14,    1, 19, 5,       0, 0);
    row(1, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);
    row(0, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);
    row(0, 0, 0,  0,       0, 0,  0,       0, 0,  0,       0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].lv, tbl[i].la, tbl[i].ld);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].we, tbl[i].add, tbl[i].data,
                    tbl[i].stall, tbl[i].rdy);
    end

    // Randomized run; pipe inputs are held whenever the model expects a stall.
    r_pw = 0; r_pa = '0; r_pd = '0;
    m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = (c == 0) || ($urandom_range(0, 149) == 0);
      if (!m_stall) begin
        r_pw = ($urandom_range(0, 3) != 0);
        r_pa = 5'($urandom_range(0, 7));
        r_pd = $urandom;
      end
      r_lv = ($urandom_range(0, 1) != 0);
      r_la = 5'($urandom_range(0, 7));
      r_ld = $urandom;
      model_step(r_rst, r_pw, r_pa, r_pd, r_lv, r_la, r_ld);
      drive(r_rst, r_pw, r_pa, r_pd, r_lv, r_la, r_ld);
      @(posedge clk);
      #1;
      check_outputs($sformatf("rnd%0d", c), m_we, m_add, m_data, m_stall,
                    mq.size() < DEPTH);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage and a long-latency execution unit (multiply/divide, load-miss return). It sits directly after the writeback pipeline register and drives the register-file write port. Long-latency results are held in a small buffer and written in idle port slots. A starvation counter briefly stalls the pipeline when the buffer cannot otherwise drain.

## Interface
- DEPTH, 2: hold-buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4: consecutive pipeline-won cycles with a non-empty buffer before a forced drain (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- pipe_data  in  32  writeback-stage result
- pipe_write_reg  in  1  writeback-stage write enable
- pipe_add  in  5  writeback-stage destination register
- pipe_stall  out  1  registered; pipeline must hold pipe_* stable this cycle
- lu_valid  in  1  long-latency result offered
- lu_data  in  32  long-latency result
- lu_add  in  5  long-latency destination
- lu_ready  out  1  buffer can accept; transfer = lu_valid & lu_ready
- rf_we  out  1  registered register-file write enable
- rf_add  out  5  registered write address
- rf_data  out  32  registered write data

## Operation
- Pipe request is live when pipe_write_reg=1 and pipe_add≠0. A write with pipe_add=0 is a no-op and never wins the port.
- An LU transfer to register 0 is accepted and discarded.
- lu_ready = (count < DEPTH), combinational from registered count.
- Per-cycle grant, evaluated in order:
  1. pipe_stall=1: dequeue the head (forced drain); the pipe request is not granted.
  2. Live pipe request: pipe is granted. If count>0, starve_cnt increments.
  3. count>0: dequeue the head; starve_cnt clears.
  4. LU transfer with count=0: direct write (bypass), not enqueued.
  5. Otherwise: rf_we=0 next cycle.
- An LU transfer not used as a bypass is enqueued at the tail. Enqueue and dequeue in the same cycle are legal; count is unchanged.
- WAW kill: a granted pipe write marks dead every buffered entry, and any same-cycle LU transfer, whose add equals pipe_add.
  - Dead entries still occupy slots and dequeue normally with rf_we=0 in their slot.
  - The pipeline instruction is by contract younger.
- Starvation: pipe_stall is set for the next cycle when starve_cnt reaches STARVE_LIMIT with count>0. It is high for exactly one cycle, then starve_cnt clears.
- FSM states:
  - EMPTY: count=0. → PENDING on enqueue.
  - PENDING: count>0, no stall. → DRAIN on the starve condition. → EMPTY when the last entry dequeues with no enqueue.
  - DRAIN: pipe_stall=1, one cycle. → PENDING or EMPTY by resulting count.
- Reset values: rf_we=0, rf_add=0, rf_data=0, pipe_stall=0, count=0, starve_cnt=0, all entries dead, state EMPTY.
- Reset mid-operation discards buffered results; upstream reissues them.

## Timing
- Grant to register-file write: 1 cycle, registered outputs.
- Bypass LU result: written the cycle after transfer.
- Buffered LU result: written the cycle after its dequeue.
- Worst-case buffered wait: (STARVE_LIMIT+1)·count cycles.
- Cycle with pipe_stall=1: pipe_* held. The held pipe request is granted the following cycle, with priority over the buffer.
- lu_ready=0 on a full buffer, even if a dequeue occurs that cycle; no full-cycle pass-through.
- Counter widths:
  - count: $clog2(DEPTH+1)
  - starve_cnt: $clog2(STARVE_LIMIT+1), saturating at STARVE_LIMIT
  - FIFO pointers: $clog2(DEPTH), wrapping modulo DEPTH

## Structure
- Shared package wb_pkg:
  - wb_req_t {we, add[4:0], data[31:0]}
  - REG_ZERO = 5'd0
  - arbiter state enum {EMPTY, PENDING, DRAIN}
- Sub-module wb_hold_fifo holds the circular buffer:
  - push, pop, and a per-entry kill-by-address compare
  - count, full and empty outputs
- wb_port_arbiter keeps the grant logic, starve counter, FSM and output registers.

## Test plan
- Reset asserted while count=2 → next cycle rf_we=0, lu_ready=1, pipe_stall=0, and no buffered write ever appears.
- Idle pipe; LU transfer (add=5, data=0x1234) → rf_we=1, rf_add=5, rf_data=0x1234 one cycle later; count stays 0.
- Continuous live pipe writes; LU transfers to add 7 and add 8 → count=2, lu_ready=0. After 4 pipe-won cycles, pipe_stall=1 for one cycle and add 7 is written. The held pipe write lands next. The add 8 entry drains after 4 more cycles.
- Buffered entry add=9; pipe writes add=9 with data 0xAAAA → rf writes 0xAAAA. The buffered entry later dequeues with rf_we=0.
- Pipe write to add 0 in the same cycle as an LU transfer to add 3 → bypass writes add 3; rf_add≠0 whenever rf_we=1.
- Full buffer with a simultaneous dequeue and lu_valid=1 → no transfer that cycle. The transfer succeeds next cycle with count back at 2.
